// File: rtl/fb_pkg.sv
// Shared types for the framebuffer scanout reader and its output FIFO.
package fb_pkg;

    localparam int unsigned FB_ADDR_W = 11;
    localparam int unsigned FB_DATA_W = 8;

    typedef logic [FB_ADDR_W-1:0] fb_addr_t;
    typedef logic [FB_DATA_W-1:0] fb_data_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } scan_state_t;

    typedef struct packed {
        fb_data_t data;
        logic     eol;
        logic     eof;
    } fb_entry_t;

endpackage

// File: rtl/fb_rd_fifo.sv
// Synchronous FIFO of scanout entries; the head entry sits in a register so the
// stream outputs come straight from flops, and a write into an empty FIFO lands there.
module fb_rd_fifo
    import fb_pkg::*;
#(
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            wr_en,
    input  fb_entry_t       wr_data,
    input  logic            rd_en,
    output fb_entry_t       rd_data,
    output logic [CntW-1:0] count,
    output logic            empty,
    output logic            full
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fb_entry_t       mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    fb_entry_t       head_q, head_d;
    logic            empty_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q + PtrW'(rd_en);
        wr_ptr_d = wr_ptr_q + PtrW'(wr_en);
        count_d  = count_q + CntW'(wr_en) - CntW'(rd_en);
        head_d   = head_q;
        // When the read leaves nothing stored, the incoming write becomes the new head.
        if (count_d != '0) begin
            head_d = (count_q == CntW'(rd_en)) ? wr_data : mem_q[rd_ptr_d];
        end
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            empty_q  <= 1'b1;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            empty_q  <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = head_q;
    assign count   = count_q;
    assign empty   = empty_q;
    assign full    = (count_q == CntW'(DEPTH));

endmodule

// File: rtl/fb_scanout_reader.sv
// Framebuffer scanout reader: walks one frame through BSRAM port B and streams the
// bytes out through a credit-limited FIFO so downstream stalls never drop data.
module fb_scanout_reader
    import fb_pkg::*;
#(
    parameter int unsigned COLS       = 64,
    parameter int unsigned ROWS       = 32,
    parameter int unsigned ADDR_W     = FB_ADDR_W,
    parameter int unsigned DATA_W     = FB_DATA_W,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] fb_base,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] mem_adb,
    output logic              mem_ceb,
    output logic              mem_oceb,
    output logic              mem_wreb,
    output logic              mem_resetb,
    input  logic [DATA_W-1:0] mem_doutb,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_eol,
    output logic              pix_eof
);

    localparam int unsigned NBytes = COLS * ROWS;
    localparam int unsigned IdxW   = $clog2(NBytes + 1);
    localparam int unsigned ColW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);

    scan_state_t       state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [ADDR_W-1:0] adb_q, adb_d;
    logic              ceb_q, ceb_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] eol_q, eol_d;
    logic [RD_LAT-1:0] eof_q, eof_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              issue_eol, issue_eof;
    logic              fifo_wr, fifo_rd, fifo_empty, fifo_full;
    fb_entry_t         fifo_wdata, fifo_rdata;
    logic [CntW-1:0]   fifo_count, fifo_count_nxt;

    always_comb begin
        issue_eol = (col_q == ColW'(COLS - 1));
        issue_eof = (idx_q == IdxW'(NBytes - 1));

        fifo_wr         = vld_q[RD_LAT-1] & ~abort;
        fifo_rd         = ~fifo_empty & pix_ready;
        fifo_wdata.data = mem_doutb;
        fifo_wdata.eol  = eol_q[RD_LAT-1];
        fifo_wdata.eof  = eof_q[RD_LAT-1];
        fifo_count_nxt  = fifo_count + CntW'(fifo_wr) - CntW'(fifo_rd);

        // Read-latency pipeline: head takes this cycle's issue, tail feeds the FIFO.
        vld_d = RD_LAT'({vld_q, ceb_q});
        eol_d = RD_LAT'({eol_q, issue_eol});
        eof_d = RD_LAT'({eof_q, issue_eof});

        state_d = state_q;
        idx_d   = idx_q + IdxW'(ceb_q);
        adb_d   = adb_q + ADDR_W'(ceb_q);
        col_d   = col_q;
        done_d  = 1'b0;
        if (ceb_q) begin
            col_d = (col_q == ColW'(COLS - 1)) ? '0 : col_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    idx_d   = '0;
                    col_d   = '0;
                    adb_d   = fb_base;
                end
            end
            ISSUE: begin
                if (idx_d == IdxW'(NBytes)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (vld_q == '0 && fifo_count_nxt == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
            vld_d   = '0;
            done_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
        // Credit is evaluated on next-cycle occupancy, so an issue is only made when
        // its byte is guaranteed a FIFO slot.
        ceb_d  = (state_d == ISSUE)
              && (int'(fifo_count_nxt) + $countones(vld_d) < int'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            col_q   <= '0;
            adb_q   <= '0;
            ceb_q   <= 1'b0;
            vld_q   <= '0;
            eol_q   <= '0;
            eof_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
            adb_q   <= adb_d;
            ceb_q   <= ceb_d;
            vld_q   <= vld_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    fb_rd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (abort),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (!reset && fifo_wr) begin
            assert (!fifo_full);
        end
    end

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign mem_adb    = adb_q;
    assign mem_ceb    = ceb_q;
    assign mem_oceb   = (RD_LAT == 2);
    assign mem_wreb   = 1'b0;
    assign mem_resetb = reset;
    assign pix_data   = fifo_rdata.data;
    assign pix_eol    = fifo_rdata.eol;
    assign pix_eof    = fifo_rdata.eof;
    assign pix_valid  = ~fifo_empty;

endmodule
